audio_sample_sequencer: RTL
===========================

# audio_sample_sequencer

Sequences the single-port sample memory for the audio recorder. Driven by the transport controller's `StartRecord`/`StartPlay` levels, it paces capture and playback with a sample-rate tick and generates memory addresses and strobes. It reports `MemoryFull` and `StopReading` back to the transport controller, and delivers played samples to the audio output path.

## Interface
- `ADDR_WIDTH`, 3: sample memory address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 8: sample width.
- `SAMPLE_DIV`, 4: clock cycles per sample period; must be ≥4.

- `Clock` in 1: system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `StartRecord` in 1: level, record session active.
- `StartPlay` in 1: level, playback session active.
- `SampleIn` in DATA_WIDTH: audio input sample.
- `MemRdData` in DATA_WIDTH: memory read data, valid the cycle after `MemRdEn`.
- `MemAddr` out ADDR_WIDTH: memory address.
- `MemWrData` out DATA_WIDTH: memory write data.
- `MemWrEn` out 1: one-cycle write strobe.
- `MemRdEn` out 1: one-cycle read strobe.
- `SampleOut` out DATA_WIDTH: last played sample; held between updates.
- `SampleValid` out 1: one-cycle pulse when `SampleOut` updates.
- `MemoryFull` out 1: level, recording filled memory.
- `StopReading` out 1: level, playback reached end of recording.
- `RecordedLength` out ADDR_WIDTH+1: samples in the last recording, 0..2^ADDR_WIDTH.

## Operation
- States: IDLE, RECORD, FULL, PLAY, DONE. All outputs are registered.
- Tick counter: held at 0 outside RECORD/PLAY. In those states it counts 0..SAMPLE_DIV-1 and wraps. A tick occurs when count = SAMPLE_DIV-1.
- IDLE → RECORD when `StartRecord`=1. On entry: WrPtr=0, RecordedLength=0.
- IDLE → PLAY when `StartPlay`=1 and `StartRecord`=0. On entry: RdPtr=0. Record has priority when both are high.
- RECORD, on tick:
  - Next cycle: `MemWrEn`=1, `MemAddr`=WrPtr, `MemWrData`=`SampleIn` sampled at the tick.
  - Then WrPtr and RecordedLength increment.
  - If the write is to address 2^ADDR_WIDTH-1, go to FULL with RecordedLength=2^ADDR_WIDTH.
- RECORD → IDLE when `StartRecord`=0. A pending tick is discarded. RecordedLength keeps the number of completed writes.
- FULL: `MemoryFull`=1 and no writes. FULL → IDLE when `StartRecord`=0, which clears `MemoryFull`.
- PLAY, when RecordedLength=0: go to DONE at the next edge; no reads occur.
- PLAY, on tick with RdPtr<RecordedLength:
  - Next cycle: `MemRdEn`=1, `MemAddr`=RdPtr; then RdPtr increments.
  - The cycle after the strobe, `MemRdData` is captured.
  - The following cycle, `SampleOut` is updated and `SampleValid` pulses.
- PLAY, on tick with RdPtr=RecordedLength: go to DONE.
- DONE: `StopReading`=1. DONE → IDLE when `StartPlay`=0, which clears `StopReading`.
- PLAY → IDLE when `StartPlay`=0. A read already issued still completes its `SampleValid` pulse.
- `MemAddr` holds its last value when idle.
- Reset mid-operation: all state clears immediately, including RecordedLength. Any in-flight write or read strobe is dropped.

## Timing
- Reset values: all outputs 0.
- First tick: SAMPLE_DIV cycles after the RECORD/PLAY entry edge.
- Write latency: tick → `MemWrEn` in 1 cycle.
- Read latency: tick → `MemRdEn` in 1 cycle → `SampleValid` 2 cycles later, so 3 cycles from the tick.
- `MemoryFull` rises in the same cycle as the final `MemWrEn`.
- `StopReading` rises 1 cycle after the terminating tick, one full sample period after the last read.
- `MemWrEn` and `MemRdEn` are never high together.

## Configuration
- `LOOP_PLAYBACK_EN` defined:
  - A tick in PLAY with RdPtr=RecordedLength (>0) reads address 0 and sets RdPtr=1.
  - Playback loops until `StartPlay` falls.
  - `StopReading` is asserted only for RecordedLength=0.
- `LOOP_PLAYBACK_EN` undefined: single-pass playback as described in Operation.

## Test plan
- Reset mid-RECORD after 3 writes → all outputs 0 asynchronously; a subsequent PLAY asserts `StopReading` 1 cycle after PLAY entry.
- Record fill, SAMPLE_DIV=4, ADDR_WIDTH=3, `SampleIn`=0x10+n → 8 writes to addr 0..7, one every 4 cycles; `MemoryFull`=1 with the 8th write; RecordedLength=8; no further writes while `StartRecord` stays high.
- Record 3 samples, drop `StartRecord` → RecordedLength=3; PLAY issues reads to 0,1,2 with `SampleOut`=0x10,0x11,0x12, each 3 cycles after its tick; `StopReading` 1 cycle after the 4th tick.
- `StartRecord`=`StartPlay`=1 from IDLE → RECORD entered; `MemRdEn` never asserted.
- `StartPlay` dropped 1 cycle after a `MemRdEn` → `SampleValid` still pulses once; state returns to IDLE; `StopReading` stays 0.
- With `LOOP_PLAYBACK_EN` and RecordedLength=2 → read address sequence 0,1,0,1,0; `StopReading` stays 0.

Source files
------------

// File: rtl/audio_sample_sequencer.sv
// audio_sample_sequencer
//   Sequences a single-port sample memory for record and playback. A sample-rate
//   tick paces one memory access per sample period.
//
//   Build option: LOOP_PLAYBACK_EN
//     defined   - playback wraps to address 0 and repeats until StartPlay falls
//     undefined - single-pass playback ending in DONE
//
//   Ports
//     Clock, Reset          : system clock (rising edge), async active-low reset
//     StartRecord/StartPlay : session levels from the transport controller
//     SampleIn              : audio input sample, captured on a record tick
//     MemRdData             : memory read data, valid the cycle after MemRdEn
//     MemAddr/MemWrData     : memory address and write data (held between strobes)
//     MemWrEn/MemRdEn       : one-cycle memory strobes
//     SampleOut/SampleValid : last played sample and its one-cycle update pulse
//     MemoryFull            : recording filled the memory
//     StopReading           : playback reached the end of the recording
//     RecordedLength        : samples in the last recording (0..2^ADDR_WIDTH)
//
//   state  | meaning
//   IDLE   | no session; waiting for StartRecord / StartPlay
//   RECORD | writing one sample per tick
//   FULL   | memory filled; waiting for StartRecord to fall
//   PLAY   | reading one sample per tick
//   DONE   | recording exhausted; waiting for StartPlay to fall
module audio_sample_sequencer #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLE_DIV = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  StartRecord,
  input  logic                  StartPlay,
  input  logic [DATA_WIDTH-1:0] SampleIn,
  input  logic [DATA_WIDTH-1:0] MemRdData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWrData,
  output logic                  MemWrEn,
  output logic                  MemRdEn,
  output logic [DATA_WIDTH-1:0] SampleOut,
  output logic                  SampleValid,
  output logic                  MemoryFull,
  output logic                  StopReading,
  output logic [ADDR_WIDTH:0]   RecordedLength
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]         TICK_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {IDLE, RECORD, FULL, PLAY, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rec_len_q, rec_len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  rd_cap_q, rd_cap_d;
  logic [DATA_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  mem_full_q, mem_full_d;
  logic                  stop_q, stop_d;
  logic                  active;
  logic                  tick;

  assign active = (state_q == RECORD) || (state_q == PLAY);
  assign tick   = active && (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    rec_len_d      = rec_len_q;
    addr_d         = addr_q;
    wr_data_d      = wr_data_q;
    wr_en_d        = 1'b0;
    rd_en_d        = 1'b0;
    // Read pipeline runs independently of the FSM so an issued read always
    // delivers its sample, even after the session ends.
    rd_cap_d       = rd_en_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    mem_full_d     = mem_full_q;
    stop_d         = stop_q;
    tick_cnt_d     = '0;

    if (rd_cap_q) begin
      sample_out_d   = MemRdData;
      sample_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (StartRecord) begin
          state_d   = RECORD;
          wr_ptr_d  = '0;
          rec_len_d = '0;
        end else if (StartPlay) begin
          state_d  = PLAY;
          rd_ptr_d = '0;
        end
      end
      RECORD: begin
        if (!StartRecord) begin
          state_d = IDLE;
        end else if (tick) begin
          wr_en_d   = 1'b1;
          addr_d    = wr_ptr_q;
          wr_data_d = SampleIn;
          wr_ptr_d  = wr_ptr_q + ADDR_WIDTH'(1);
          rec_len_d = rec_len_q + (ADDR_WIDTH+1)'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_d    = FULL;
            mem_full_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (!StartRecord) begin
          state_d    = IDLE;
          mem_full_d = 1'b0;
        end
      end
      PLAY: begin
        if (!StartPlay) begin
          state_d = IDLE;
        end else if (rec_len_q == '0) begin
          state_d = DONE;
          stop_d  = 1'b1;
        end else if (tick) begin
          if (rd_ptr_q < rec_len_q) begin
            rd_en_d  = 1'b1;
            addr_d   = rd_ptr_q[ADDR_WIDTH-1:0];
            rd_ptr_d = rd_ptr_q + (ADDR_WIDTH+1)'(1);
          end else begin
`ifdef LOOP_PLAYBACK_EN
            rd_en_d  = 1'b1;
            addr_d   = '0;
            rd_ptr_d = (ADDR_WIDTH+1)'(1);
`else
            state_d = DONE;
            stop_d  = 1'b1;
`endif
          end
        end
      end
      DONE: begin
        if (!StartPlay) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter only runs while staying in RECORD/PLAY; any entry or exit restarts it at 0.
    if (active && (state_d == state_q)) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      tick_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      rec_len_q      <= '0;
      addr_q         <= '0;
      wr_data_q      <= '0;
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_cap_q       <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      mem_full_q     <= 1'b0;
      stop_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      rec_len_q      <= rec_len_d;
      addr_q         <= addr_d;
      wr_data_q      <= wr_data_d;
      wr_en_q        <= wr_en_d;
      rd_en_q        <= rd_en_d;
      rd_cap_q       <= rd_cap_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      mem_full_q     <= mem_full_d;
      stop_q         <= stop_d;
    end
  end

  assign MemAddr        = addr_q;
  assign MemWrData      = wr_data_q;
  assign MemWrEn        = wr_en_q;
  assign MemRdEn        = rd_en_q;
  assign SampleOut      = sample_out_q;
  assign SampleValid    = sample_valid_q;
  assign MemoryFull     = mem_full_q;
  assign StopReading    = stop_q;
  assign RecordedLength = rec_len_q;

endmodule
